// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit and the ALU that
// consumes its results.
package hilo_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'd0,
    MDU_DIVU  = 2'd1
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_MFHI = 4'd6,
    ALU_MFLO = 4'd7
  } alu_fn_e;

endpackage

// File: rtl/hilo_mdu.sv
// Iterative unsigned multiply/divide that owns the architectural HI/LO pair.
// Each operation takes WIDTH cycles: one result bit per cycle.
//
// state   | meaning
// ST_IDLE | HI/LO writable via mthi/mtlo, waiting for an accepted start
// ST_RUN  | iterating; HI/LO frozen, partial result in ph_q/pl_q
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign accept = (state_q == ST_IDLE) && start &&
                  ((op == MDU_MULTU) || (op == MDU_DIVU));

  // Multiply: ph/pl hold {accumulator, remaining multiplier bits}.
  // Divide:   ph/pl hold {partial remainder, dividend shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, ph_q} + (pl_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {ph_q, pl_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    if (op_q == MDU_MULTU) begin
      {step_hi, step_lo} = {mul_sum, pl_q[WIDTH-1:1]};
    end else begin
      step_hi = div_rem;
      step_lo = {pl_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          op_d    = mdu_op_e'(op);
          cnt_d   = '0;
          ph_d    = '0;
          opnd_d  = (op == MDU_MULTU) ? a : b;
          pl_d    = (op == MDU_MULTU) ? b : a;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      ST_RUN: begin
        ph_d  = step_hi;
        pl_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          hi_d    = step_hi;
          lo_d    = step_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULTU;
      cnt_q   <= '0;
      opnd_q  <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed cases plus random operations
// compared against a plain-arithmetic HI/LO model.
module tb_hilo_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] ref_hi = '0, ref_lo = '0;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (o == 2'd0) begin
      p = 64'(x) * 64'(y);
      ref_hi = p[2*W-1:W];
      ref_lo = p[W-1:0];
    end else if (y == 0) begin
      ref_hi = x;
      ref_lo = '1;
    end else begin
      ref_hi = x % y;
      ref_lo = x / y;
    end
  endtask

  // inj_at >= 0 drives a stray MULTU start and an mtlo at that busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int inj_at, input bit mt_with_start);
    logic [W-1:0] old_hi, old_lo;
    old_hi = ref_hi;
    old_lo = ref_lo;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    mthi = mt_with_start; mtlo = mt_with_start; wdata = $urandom;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom;
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      check("busy_run", W'(busy), W'(1));
      check("done_run", W'(done), W'(0));
      check("hi_hold", hi, old_hi);
      check("lo_hold", lo, old_lo);
      if (i == inj_at) begin
        start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
        mtlo = 1'b1; wdata = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    model(o, x, y);
    check("busy_end", W'(busy), W'(0));
    check("done_pulse", W'(done), W'(1));
    check("hi_result", hi, ref_hi);
    check("lo_result", lo, ref_lo);
    @(negedge clk);
    check("done_low", W'(done), W'(0));
    check("busy_idle", W'(busy), W'(0));
  endtask

  task automatic do_mt(input bit wh, input bit wl, input logic [W-1:0] d);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) ref_hi = d;
    if (wl) ref_lo = d;
    check("mt_hi", hi, ref_hi);
    check("mt_lo", lo, ref_lo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    reset = 1'b0;

    do_op(2'd0, 32'd6, 32'd7, -1, 1'b0);
    check("mul_6x7_lo", lo, 32'h0000002A);
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    check("mul_max_hi", hi, 32'hFFFFFFFE);
    do_op(2'd1, 32'd100, 32'd7, -1, 1'b0);
    check("div_100_7_lo", lo, 32'd14);
    do_op(2'd1, 32'd5, 32'd0, -1, 1'b0);
    check("div_by0_lo", lo, 32'hFFFFFFFF);
    do_op(2'd1, 32'd100, 32'd7, 9, 1'b0);
    check("div_inj_hi", hi, 32'd2);

    do_mt(1'b1, 1'b0, 32'h1234);
    check("mthi_1234", hi, 32'h1234);
    do_mt(1'b1, 1'b1, $urandom);
    do_op(2'd0, $urandom, $urandom, 20, 1'b1);

    // reserved op must not start anything
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b1; op = 2'd3;
    check("rsv2_busy", W'(busy), W'(0));
    @(negedge clk);
    start = 1'b0;
    check("rsv3_busy", W'(busy), W'(0));
    check("rsv_hi", hi, ref_hi);

    // reset in mid-run
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_hi", hi, '0);
    check("mid_rst_lo", lo, '0);
    ref_hi = '0; ref_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    do_op(2'd0, 32'd3, 32'd3, -1, 1'b0);
    check("mul_3x3_lo", lo, 32'd9);

    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra, rb;
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) do_mt(1'($urandom), 1'($urandom), $urandom);
      do_op(ro, ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W-1)) : -1,
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and HI/LO width; iteration count equals WIDTH.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous and active-high.
REQ-004 Port start  input  1  one-cycle request to begin the operation selected by op.
REQ-005 Port op  input  2  operation: 0 MULTU, 1 DIVU, 2/3 reserved (start ignored).
REQ-006 Port a  input  WIDTH  multiplicand / dividend, captured when start is accepted.
REQ-007 Port b  input  WIDTH  multiplier / divisor, captured when start is accepted.
REQ-008 Port mthi  input  1  write wdata into HI.
REQ-009 Port mtlo  input  1  write wdata into LO.
REQ-010 Port wdata  input  WIDTH  data for mthi/mtlo.
REQ-011 Port busy  output  1  operation in progress; pipeline stalls HI/LO consumers while high.
REQ-012 Port done  output  1  one-cycle pulse: new HI/LO visible this cycle.
REQ-013 Port hi  output  WIDTH  architectural HI register, fed to the ALU hi input.
REQ-014 Port lo  output  WIDTH  architectural LO register, fed to the ALU lo input.

Function
REQ-015 The FSM SHALL have states IDLE and RUN; done is a registered flag, not a state.
REQ-016 In IDLE with start=1 and op in {0,1}, on the clock edge the block SHALL latch a and b, clear the iteration counter, and enter RUN.
REQ-017 busy SHALL equal (state==RUN): high for exactly WIDTH cycles after acceptance.
REQ-018 MULTU SHALL be unsigned shift-add, one multiplier bit per cycle; the final {hi,lo} equals the 2*WIDTH-bit product a*b.
REQ-019 DIVU SHALL be unsigned restoring division, one quotient bit per cycle; final lo=a/b and hi=a%b.
REQ-020 With b==0, DIVU SHALL still take WIDTH cycles and produce lo=all-ones and hi=a.
REQ-021 hi/lo SHALL hold their previous values throughout RUN, with partial results kept in internal registers, and SHALL update only on the WIDTH-th RUN edge, which also returns the FSM to IDLE.
REQ-022 done SHALL be high for exactly the one cycle after the updating edge; otherwise low.
REQ-023 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-024 mthi/mtlo in IDLE SHALL write wdata to HI/LO on the edge, and may both be asserted together.
REQ-025 mthi/mtlo while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-026 Operands captured at acceptance SHALL be used for the whole operation; later changes on a and b have no effect.
REQ-027 Counter width SHALL be $clog2(WIDTH)+1 bits; it SHALL NOT wrap during an operation.

Reset
REQ-028 Asserting reset at any time, including mid-RUN, SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear counter and internal registers.
REQ-029 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-030 The op encoding (enum MDU_MULTU, MDU_DIVU) and the FSM state enum SHALL live in the shared package, alongside the ALU function codes.
REQ-031 The block SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-032 MULTU a=6, b=7 -> busy high 32 cycles, then done pulse with hi=0x00000000, lo=0x0000002A.
REQ-033 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIVU a=100, b=7 -> lo=14, hi=2; then DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 DIVU 100/7 then a second start (op=MULTU) at busy cycle 10 -> ignored; result still lo=14, hi=2, busy not extended.
REQ-036 mthi wdata=0x1234 in IDLE -> hi=0x1234 next cycle; mtlo while busy -> lo unchanged.
REQ-037 MULTU 6*7 with reset pulsed at busy cycle 15 -> busy, done, hi, lo all 0 immediately; a new 3*3 afterwards -> lo=9 after 32 cycles.
